tcp_seg_rx: RTL and testbench

Byte-serial TCP segment header parser that sits directly upstream of the TCP connection FSM. It accepts a received segment one byte per beat and extracts the header fields. It checks the destination port and data offset, then converts the flags byte into one-cycle strobes that drive the FSM's `ACK_i`/`FIN_i`/`RST_i`/`SYN_i` inputs. Malformed or foreign segments are discarded and counted; they never reach the FSM.

---
 rtl/tcp_seg_rx.sv | 234 +++++++++++++++++++++++
 tb/tb_tcp_seg_rx.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/tcp_seg_rx.sv
// Byte-serial TCP header parser: extracts header fields, filters foreign or malformed
// segments, and turns the flags byte into one-cycle strobes for the connection FSM.
module tcp_seg_rx #(
  parameter logic [15:0] LOCAL_PORT = 16'd80
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        rx_last,
  output logic        rx_ready,
  output logic        ack_flag,
  output logic        fin_flag,
  output logic        rst_flag,
  output logic        syn_flag,
  output logic        seg_valid,
  output logic        hdr_err,
  output logic [15:0] seg_src_port,
  output logic [31:0] seg_seq,
  output logic [31:0] seg_ack_num,
  output logic [15:0] seg_wnd,
  output logic [15:0] payload_len,
  output logic [7:0]  err_cnt
);

  typedef enum logic [2:0] {S_HDR, S_OPTS, S_PAYLOAD, S_DROP, S_EMIT} state_t;

  state_t      state_q, state_d;
  logic [5:0]  idx_q, idx_d;
  logic [15:0] plen_q, plen_d;
  logic [15:0] src_q;
  logic [7:0]  dst_hi_q;
  logic [31:0] seq_q;
  logic [31:0] ackn_q;
  logic [3:0]  off_q;
  logic [7:0]  flags_q;
  logic [15:0] wnd_q;

  logic        ack_q, fin_q, rstf_q, syn_q, seg_valid_q, hdr_err_q;
  logic [15:0] seg_src_q, seg_wnd_q, payload_len_q;
  logic [31:0] seg_seq_q, seg_ack_q;
  logic [7:0]  err_cnt_q;

  logic        beat_s;
  logic        err_now_s;
  logic        bad_s;
  logic        emit_s;
  logic [5:0]  hdr_end_s;

  assign rx_ready = ~rst & (state_q != S_EMIT);

  always_comb begin
    beat_s    = rx_valid & rx_ready;
    state_d   = state_q;
    idx_d     = idx_q;
    plen_d    = plen_q;
    err_now_s = 1'b0;
    hdr_end_s = {off_q, 2'b00} - 6'd1;
    case (state_q)
      S_HDR: begin
        if (beat_s) begin
          idx_d = idx_q + 6'd1;
          if (idx_q == 6'd3 && {dst_hi_q, rx_data} != LOCAL_PORT) begin
            err_now_s = 1'b1;
          end else if (idx_q == 6'd12 && rx_data[7:4] < 4'd5) begin
            err_now_s = 1'b1;
          end else if (rx_last && idx_q < 6'd19) begin
            err_now_s = 1'b1;
          end else if (rx_last && idx_q == 6'd19 && off_q > 4'd5) begin
            // options announced but the segment stopped at the fixed header
            err_now_s = 1'b1;
          end else begin
            err_now_s = 1'b0;
          end
          if (err_now_s) begin
            state_d = rx_last ? S_EMIT : S_DROP;
          end else if (idx_q == 6'd19) begin
            if (off_q > 4'd5) begin
              state_d = S_OPTS;
            end else begin
              state_d = rx_last ? S_EMIT : S_PAYLOAD;
            end
          end else begin
            state_d = S_HDR;
          end
        end else begin
          state_d = S_HDR;
        end
      end
      S_OPTS: begin
        if (beat_s) begin
          idx_d = idx_q + 6'd1;
          if (idx_q == hdr_end_s) begin
            state_d = rx_last ? S_EMIT : S_PAYLOAD;
          end else if (rx_last) begin
            err_now_s = 1'b1;
            state_d   = S_EMIT;
          end else begin
            state_d = S_OPTS;
          end
        end else begin
          state_d = S_OPTS;
        end
      end
      S_PAYLOAD: begin
        if (beat_s) begin
          if (plen_q != 16'hFFFF) begin
            plen_d = plen_q + 16'd1;
          end else begin
            plen_d = plen_q;
          end
          state_d = rx_last ? S_EMIT : S_PAYLOAD;
        end else begin
          state_d = S_PAYLOAD;
        end
      end
      S_DROP: begin
        if (beat_s && rx_last) begin
          state_d = S_EMIT;
        end else begin
          state_d = S_DROP;
        end
      end
      S_EMIT: begin
        state_d = S_HDR;
        idx_d   = 6'd0;
        plen_d  = 16'd0;
      end
      default: begin
        state_d = S_HDR;
        idx_d   = 6'd0;
        plen_d  = 16'd0;
      end
    endcase
    // DROP is only ever entered after an error, so it doubles as the sticky error bit
    bad_s  = err_now_s | (state_q == S_DROP);
    emit_s = (state_d == S_EMIT) && (state_q != S_EMIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_HDR;
      idx_q   <= 6'd0;
      plen_q  <= 16'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      plen_q  <= plen_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      src_q    <= 16'd0;
      dst_hi_q <= 8'd0;
      seq_q    <= 32'd0;
      ackn_q   <= 32'd0;
      off_q    <= 4'd0;
      flags_q  <= 8'd0;
      wnd_q    <= 16'd0;
    end else if (state_q == S_HDR && beat_s) begin
      case (idx_q)
        6'd0:                      src_q[15:8] <= rx_data;
        6'd1:                      src_q[7:0]  <= rx_data;
        6'd2:                      dst_hi_q    <= rx_data;
        6'd4, 6'd5, 6'd6, 6'd7:    seq_q       <= {seq_q[23:0], rx_data};
        6'd8, 6'd9, 6'd10, 6'd11:  ackn_q      <= {ackn_q[23:0], rx_data};
        6'd12:                     off_q       <= rx_data[7:4];
        6'd13:                     flags_q     <= rx_data;
        6'd14:                     wnd_q[15:8] <= rx_data;
        6'd15:                     wnd_q[7:0]  <= rx_data;
        default: ;
      endcase
    end
  end

  // Strobes and field outputs load on the edge that accepts the final beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_q         <= 1'b0;
      fin_q         <= 1'b0;
      rstf_q        <= 1'b0;
      syn_q         <= 1'b0;
      seg_valid_q   <= 1'b0;
      hdr_err_q     <= 1'b0;
      seg_src_q     <= 16'd0;
      seg_seq_q     <= 32'd0;
      seg_ack_q     <= 32'd0;
      seg_wnd_q     <= 16'd0;
      payload_len_q <= 16'd0;
      err_cnt_q     <= 8'd0;
    end else begin
      ack_q       <= 1'b0;
      fin_q       <= 1'b0;
      rstf_q      <= 1'b0;
      syn_q       <= 1'b0;
      seg_valid_q <= 1'b0;
      hdr_err_q   <= 1'b0;
      if (emit_s) begin
        if (bad_s) begin
          hdr_err_q <= 1'b1;
          if (err_cnt_q != 8'hFF) begin
            err_cnt_q <= err_cnt_q + 8'd1;
          end
        end else begin
          seg_valid_q   <= 1'b1;
          fin_q         <= flags_q[0];
          syn_q         <= flags_q[1];
          rstf_q        <= flags_q[2];
          ack_q         <= flags_q[4];
          seg_src_q     <= src_q;
          seg_seq_q     <= seq_q;
          seg_ack_q     <= ackn_q;
          seg_wnd_q     <= wnd_q;
          payload_len_q <= plen_d;
        end
      end
    end
  end

  assign ack_flag     = ack_q;
  assign fin_flag     = fin_q;
  assign rst_flag     = rstf_q;
  assign syn_flag     = syn_q;
  assign seg_valid    = seg_valid_q;
  assign hdr_err      = hdr_err_q;
  assign seg_src_port = seg_src_q;
  assign seg_seq      = seg_seq_q;
  assign seg_ack_num  = seg_ack_q;
  assign seg_wnd      = seg_wnd_q;
  assign payload_len  = payload_len_q;
  assign err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_tcp_seg_rx.sv
// Bench for tcp_seg_rx: table of segments driven byte-serially, expected results queued
// per segment and compared when the parser emits its strobe.
module tb_tcp_seg_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_last;
  logic        rx_ready;
  logic        ack_flag, fin_flag, rst_flag, syn_flag;
  logic        seg_valid, hdr_err;
  logic [15:0] seg_src_port, seg_wnd, payload_len;
  logic [31:0] seg_seq, seg_ack_num;
  logic [7:0]  err_cnt;

  always #5 clk = ~clk;

  tcp_seg_rx #(.LOCAL_PORT(16'd80)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .rx_last(rx_last),
    .rx_ready(rx_ready), .ack_flag(ack_flag), .fin_flag(fin_flag), .rst_flag(rst_flag),
    .syn_flag(syn_flag), .seg_valid(seg_valid), .hdr_err(hdr_err),
    .seg_src_port(seg_src_port), .seg_seq(seg_seq), .seg_ack_num(seg_ack_num),
    .seg_wnd(seg_wnd), .payload_len(payload_len), .err_cnt(err_cnt)
  );

  typedef struct {
    logic [15:0] dst;
    logic [3:0]  off;
    logic [7:0]  flags;
    logic [31:0] seq;
    int          npay;
    int          runt;      // index of an early rx_last, -1 for a full segment
    bit          exp_err;
    logic [3:0]  exp_strb;  // {ack, rst, syn, fin}
    logic [15:0] exp_plen;
  } vec_t;

  typedef struct {
    bit          err;
    logic [3:0]  strb;
    logic [15:0] plen;
    logic [15:0] src;
    logic [31:0] seq;
    logic [31:0] ack;
    logic [15:0] wnd;
    logic [7:0]  ecnt;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  int          low_cnt = 0;
  int          emit_cnt = 0;
  bit          pend = 1'b0;
  logic [15:0] m_src, m_wnd, m_plen;
  logic [31:0] m_seq, m_ack;
  logic [7:0]  m_ecnt;
  vec_t        tbl[10];
  vec_t        v_tmp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_beat(input logic [7:0] d, input logic last);
    bit acc;
    int n;
    rx_valid = 1'b1;
    rx_data  = d;
    rx_last  = last;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 8) begin
      @(negedge clk);
      acc = rx_ready;
      @(posedge clk);
      #1;
      n++;
    end
    chk("beat_accepted", {31'd0, acc}, 32'd1);
    rx_valid = 1'b0;
    rx_last  = 1'b0;
  endtask

  // rst_at >= 0 drives that byte together with a reset pulse and abandons the segment
  task automatic send_seg(input vec_t v, input int rst_at);
    logic [7:0]  b[$];
    logic [15:0] src, wnd;
    logic [31:0] ackn;
    int          hl, last;
    exp_t        e;
    src  = v.seq[15:0] ^ 16'hA5A5;
    ackn = ~v.seq;
    wnd  = v.seq[31:16] + 16'd1;
    hl   = (v.off > 4'd5) ? 4 * int'(v.off) : 20;
    b.push_back(src[15:8]);   b.push_back(src[7:0]);
    b.push_back(v.dst[15:8]); b.push_back(v.dst[7:0]);
    for (int i = 3; i >= 0; i--) b.push_back(v.seq[i*8 +: 8]);
    for (int i = 3; i >= 0; i--) b.push_back(ackn[i*8 +: 8]);
    b.push_back({v.off, 4'h0}); b.push_back(v.flags);
    b.push_back(wnd[15:8]);     b.push_back(wnd[7:0]);
    for (int i = 0; i < 4; i++) b.push_back(8'h00);
    for (int i = 20; i < hl; i++) b.push_back(8'h01);
    for (int i = 0; i < v.npay; i++) b.push_back(8'(i + 48));
    last = (v.runt >= 0) ? v.runt : b.size() - 1;
    if (rst_at < 0) begin
      if (!v.exp_err) begin
        m_src = src; m_seq = v.seq; m_ack = ackn; m_wnd = wnd; m_plen = v.exp_plen;
      end else if (m_ecnt != 8'hFF) begin
        m_ecnt = m_ecnt + 8'd1;
      end
      e.err = v.exp_err; e.strb = v.exp_err ? 4'b0000 : v.exp_strb; e.plen = m_plen;
      e.src = m_src; e.seq = m_seq; e.ack = m_ack; e.wnd = m_wnd; e.ecnt = m_ecnt;
      sbq.push_back(e);
    end
    for (int i = 0; i <= last; i++) begin
      if (i == rst_at) begin
        rx_valid = 1'b1;
        rx_data  = b[i];
        rst      = 1'b1;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        rx_valid = 1'b0;
        break;
      end
      drive_beat(b[i], i == last);
    end
  endtask

  // Scoreboard side: an emit strobe must follow an accepted rx_last by exactly one cycle.
  always @(negedge clk) begin
    if (rst) begin
      pend = 1'b0;
    end else begin
      if (!rx_ready) low_cnt++;
      chk("emit_timing", {31'd0, seg_valid | hdr_err}, {31'd0, pend});
      if (seg_valid || hdr_err) begin
        emit_cnt++;
        if (sbq.size() == 0) begin
          chk("unexpected_emit_queue", 32'd0, 32'd1);
        end else begin
          mon_e = sbq.pop_front();
          chk("hdr_err",      {31'd0, hdr_err},   {31'd0, mon_e.err});
          chk("seg_valid",    {31'd0, seg_valid}, {31'd0, !mon_e.err});
          chk("flag_strobes", {28'd0, ack_flag, rst_flag, syn_flag, fin_flag}, {28'd0, mon_e.strb});
          chk("payload_len",  {16'd0, payload_len},  {16'd0, mon_e.plen});
          chk("seg_src_port", {16'd0, seg_src_port}, {16'd0, mon_e.src});
          chk("seg_seq",      seg_seq,               mon_e.seq);
          chk("seg_ack_num",  seg_ack_num,           mon_e.ack);
          chk("seg_wnd",      {16'd0, seg_wnd},      {16'd0, mon_e.wnd});
          chk("err_cnt",      {24'd0, err_cnt},      {24'd0, mon_e.ecnt});
          chk("ready_in_emit", {31'd0, rx_ready},    32'd0);
        end
      end
      pend = rx_valid && rx_ready && rx_last;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //                dst     off   flags  seq             npay runt err strb     plen
    tbl[0] = '{16'd80, 4'd5,  8'h02, 32'h0000_1000, 0, -1, 1'b0, 4'b0010, 16'd0};
    tbl[1] = '{16'd80, 4'd6,  8'h12, 32'h1234_5678, 3, -1, 1'b0, 4'b1010, 16'd3};
    tbl[2] = '{16'd81, 4'd5,  8'h10, 32'hDEAD_BEEF, 2, -1, 1'b1, 4'b0000, 16'd0};
    tbl[3] = '{16'd80, 4'd5,  8'h10, 32'h0BAD_0001, 0, 10, 1'b1, 4'b0000, 16'd0};
    tbl[4] = '{16'd80, 4'd5,  8'h11, 32'hCAFE_0042, 5, -1, 1'b0, 4'b1001, 16'd5};
    tbl[5] = '{16'd80, 4'd4,  8'h10, 32'h0000_0004, 0, -1, 1'b1, 4'b0000, 16'd0};
    tbl[6] = '{16'd80, 4'd7,  8'h10, 32'h0000_0007, 4, 22, 1'b1, 4'b0000, 16'd0};
    tbl[7] = '{16'd80, 4'd8,  8'h04, 32'h8000_0000, 1, -1, 1'b0, 4'b0100, 16'd1};
    tbl[8] = '{16'd80, 4'd6,  8'h10, 32'h0000_0006, 0, 19, 1'b1, 4'b0000, 16'd0};
    tbl[9] = '{16'd80, 4'd15, 8'h10, 32'hFFFF_FFFF, 2, -1, 1'b0, 4'b1000, 16'd2};

    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'd0; rx_last = 1'b0;
    m_src = 16'd0; m_seq = 32'd0; m_ack = 32'd0; m_wnd = 16'd0; m_plen = 16'd0; m_ecnt = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ready",  {31'd0, rx_ready}, 32'd0);
    chk("reset_strobes", {26'd0, seg_valid, hdr_err, ack_flag, rst_flag, syn_flag, fin_flag}, 32'd0);
    chk("reset_seq",    seg_seq, 32'd0);
    chk("reset_plen",   {16'd0, payload_len}, 32'd0);
    chk("reset_errcnt", {24'd0, err_cnt}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", {31'd0, rx_ready}, 32'd1);
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) send_seg(tbl[i], -1);
    repeat (3) @(posedge clk); #1;

    // Reset in the middle of a FIN segment: partial segment vanishes, state returns to reset.
    v_tmp = '{16'd80, 4'd5, 8'h01, 32'h0000_F1F1, 0, -1, 1'b0, 4'b0001, 16'd0};
    send_seg(v_tmp, 7);
    m_src = 16'd0; m_seq = 32'd0; m_ack = 32'd0; m_wnd = 16'd0; m_plen = 16'd0; m_ecnt = 8'd0;
    @(negedge clk);
    chk("ready_after_midrst", {31'd0, rx_ready}, 32'd1);
    chk("errcnt_after_midrst", {24'd0, err_cnt}, 32'd0);
    chk("seq_after_midrst", seg_seq, 32'd0);
    @(posedge clk); #1;
    send_seg(v_tmp, -1);

    // Saturate the discard counter with one-byte runts.
    v_tmp = '{16'd80, 4'd5, 8'h00, 32'h0, 0, 0, 1'b1, 4'b0000, 16'd0};
    for (int i = 0; i < 260; i++) send_seg(v_tmp, -1);
    repeat (2) @(posedge clk); #1;
    chk("err_cnt_saturated", {24'd0, err_cnt}, 32'd255);

    // Back-to-back good segments.
    send_seg(tbl[0], -1);
    send_seg(tbl[4], -1);
    send_seg(tbl[1], -1);
    repeat (4) @(posedge clk); #1;
    chk("one_bubble_per_emit", low_cnt, emit_cnt);
    chk("scoreboard_drained", sbq.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
